logic_unit_arbiter: RTL and testbench

- Shares one WIDTH-bit bitwise logic unit (AND / OR / XOR / NAND) between two requesters using a 4-phase req/done handshake.
- Round-robin grant; operands latched on grant; result registered and held until the granted requester drops req.
- Sits between the gate-level 16-bit chips and the higher-level sequencing logic that needs bitwise results.

---
 rtl/logic_unit_arbiter.sv | 134 +++++++++++++
 tb/tb_logic_unit_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - two-requester round-robin arbiter around a shared bitwise logic unit
module logic_unit_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       op1,
  output logic             grant0,
  output logic             grant1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;       // requester served most recently; loses the next tie
  logic             owner;      // requester currently holding the unit
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic [1:0]       op_l;
  logic             grant_fire;
  logic             pick;
  logic             owner_req;
  logic [WIDTH-1:0] result;

  // Next-state and arbitration decision; a tie goes to whoever was not served last
  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    pick       = 1'b0;
    owner_req  = owner ? req1 : req0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_fire = 1'b1;
          pick       = (req0 && req1) ? ~last : req1;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = DONE;
      DONE: begin
        if (!owner_req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bitwise logic unit on the latched operands
  always_comb begin
    result = '0;
    case (op_l)
      2'b00:   result = a_l & b_l;
      2'b01:   result = a_l | b_l;
      2'b10:   result = a_l ^ b_l;
      default: result = ~(a_l & b_l);
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant/done flags, operand capture at grant, and the registered result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant0 <= 1'b0;
      grant1 <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      out    <= '0;
      zero   <= 1'b1;
      last   <= 1'b1;
      owner  <= 1'b0;
      a_l    <= '0;
      b_l    <= '0;
      op_l   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (grant_fire) begin
            owner  <= pick;
            grant0 <= ~pick;
            grant1 <= pick;
            a_l    <= pick ? a1 : a0;
            b_l    <= pick ? b1 : b0;
            op_l   <= pick ? op1 : op0;
          end
        end
        EXEC: begin
          out   <= result;
          zero  <= (result == '0);
          done0 <= ~owner;
          done1 <= owner;
        end
        DONE: begin
          if (!owner_req) begin
            done0  <= 1'b0;
            done1  <= 1'b0;
            grant0 <= 1'b0;
            grant1 <= 1'b0;
            last   <= owner;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

  logic        clk;
  logic        reset;
  logic        req0;
  logic [15:0] a0;
  logic [15:0] b0;
  logic [1:0]  op0;
  logic        req1;
  logic [15:0] a1;
  logic [15:0] b1;
  logic [1:0]  op1;
  logic        grant0;
  logic        grant1;
  logic        done0;
  logic        done1;
  logic [15:0] out;
  logic        zero;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int last_served;

  bit          want [2];
  logic [15:0] opa  [2];
  logic [15:0] opb  [2];
  logic [1:0]  opc  [2];

  logic [15:0] tp_exp [4];

  logic_unit_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .out(out), .zero(zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] lu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_reqs();
    req0 = want[0]; a0 = opa[0]; b0 = opb[0]; op0 = opc[0];
    req1 = want[1]; a1 = opa[1]; b1 = opb[1]; op1 = opc[1];
  endtask

  // One complete transaction for a single requester, starting and ending in IDLE
  task automatic run_one(input int who, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input int hold, input bit mutate);
    logic [15:0] expv;
    logic [1:0]  gexp;
    expv = lu(a, b, op);
    gexp = (who == 1) ? 2'b10 : 2'b01;
    want[0] = 1'b0; want[1] = 1'b0;
    want[who] = 1'b1; opa[who] = a; opb[who] = b; opc[who] = op;
    drive_reqs();
    tick();
    chk("grant_edge1", {grant1, grant0}, gexp);
    chk("busy_exec", busy, 1);
    chk("no_early_done", {done1, done0}, 2'b00);
    if (mutate) begin
      opa[who] = 16'h1234;
      opb[who] = 16'($urandom);
      opc[who] = 2'($urandom);
      drive_reqs();
    end
    tick();
    chk("done_edge2", {done1, done0}, gexp);
    chk("out", out, expv);
    chk("zero", zero, (expv == 16'h0));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_done", {done1, done0}, gexp);
      chk("hold_out", out, expv);
    end
    want[who] = 1'b0;
    drive_reqs();
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_grant", {grant1, grant0}, 2'b00);
    chk("idle_done", {done1, done0}, 2'b00);
    chk("idle_out_kept", out, expv);
    last_served = who;
  endtask

  // One arbitration round; a losing requester stays pending into the next round
  task automatic round(input bit fixed);
    int          w;
    logic [2:0]  mask;
    logic [15:0] expv;
    mask = 3'($urandom_range(1, 3));
    if (fixed) mask = 3'b011;
    for (int i = 0; i < 2; i++) begin
      if (!want[i] && mask[i]) begin
        want[i] = 1'b1;
        if (fixed) begin
          opa[i] = 16'h00FF; opb[i] = 16'h0F0F; opc[i] = 2'b00;
        end else begin
          opa[i] = 16'($urandom); opb[i] = 16'($urandom); opc[i] = 2'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            opb[i] = opa[i]; opc[i] = 2'b10;
          end
        end
      end
    end
    drive_reqs();
    if (want[0] && want[1]) w = 1 - last_served;
    else w = want[1] ? 1 : 0;
    expv = lu(opa[w], opb[w], opc[w]);
    tick();
    chk("rr_grant", {grant1, grant0}, (w == 1) ? 2'b10 : 2'b01);
    tick();
    chk("rr_done", {done1, done0}, (w == 1) ? 2'b10 : 2'b01);
    chk("rr_out", out, expv);
    chk("rr_zero", zero, (expv == 16'h0));
    want[w] = 1'b0;
    drive_reqs();
    tick();
    chk("rr_idle", busy, 0);
    last_served = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    want[0] = 1'b0; want[1] = 1'b0;
    drive_reqs();
    tick();
    tick();
    reset = 1'b0;
    last_served = 1;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      want[i] = 1'b0; opa[i] = '0; opb[i] = '0; opc[i] = '0;
    end
    drive_reqs();
    tick();
    tick();
    chk("rst_grant", {grant1, grant0}, 2'b00);
    chk("rst_done", {done1, done0}, 2'b00);
    chk("rst_out", out, 16'h0000);
    chk("rst_zero", zero, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    last_served = 1;
    tick();
    chk("idle_no_req", busy, 0);

    run_one(0, 16'h0000, 16'hFFFF, 2'b01, 3, 1'b0);

    tp_exp[0] = 16'h8304; tp_exp[1] = 16'hE78F; tp_exp[2] = 16'h648B; tp_exp[3] = 16'h7CFB;
    for (int k = 0; k < 4; k++) begin
      run_one(1, 16'hA38C, 16'hC707, 2'(k), 0, 1'b0);
      chk("tp_const_out", out, tp_exp[k]);
    end

    run_one(1, 16'hFFFF, 16'h0000, 2'b00, 1, 1'b0);
    chk("zero_case", zero, 1);

    run_one(0, 16'hF0F0, 16'h3C3C, 2'b10, 0, 1'b1);

    // request withdrawn during EXEC still completes with a done pulse
    want[0] = 1'b1; opa[0] = 16'h5A5A; opb[0] = 16'h0FF0; opc[0] = 2'b11;
    drive_reqs();
    tick();
    chk("early_drop_grant", grant0, 1);
    want[0] = 1'b0;
    drive_reqs();
    tick();
    chk("early_drop_done", done0, 1);
    chk("early_drop_out", out, lu(16'h5A5A, 16'h0FF0, 2'b11));
    tick();
    chk("early_drop_idle", {busy, done0, grant0}, 3'b000);
    last_served = 0;

    do_reset();
    for (int r = 0; r < 4; r++) round(1'b1);
    for (int r = 0; r < 40; r++) round(1'b0);

    // reset in the middle of a transaction
    want[0] = 1'b1; want[1] = 1'b0; opa[0] = 16'hBEEF; opb[0] = 16'hFFFF; opc[0] = 2'b00;
    drive_reqs();
    tick();
    chk("pre_reset_exec", {busy, grant0}, 2'b11);
    reset = 1'b1;
    #1;
    chk("async_grant0", grant0, 0);
    chk("async_done0", done0, 0);
    chk("async_busy", busy, 0);
    chk("async_out", out, 16'h0000);
    chk("async_zero", zero, 1);
    want[0] = 1'b0;
    drive_reqs();
    tick();
    chk("in_reset_done0", done0, 0);
    reset = 1'b0;
    last_served = 1;
    run_one(0, 16'h1357, 16'h2468, 2'b01, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
